// File: rtl/spi_accel_pkg.sv
// Shared definitions for the SPI accelerometer responder: command codes,
// frame FSM states, read-only register indices and status bit positions.
package spi_accel_pkg;

    localparam logic [7:0] CMD_WR = 8'h0A;
    localparam logic [7:0] CMD_RD = 8'h0B;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR    = 3'd2,
        ST_IGNORE  = 3'd3,
        ST_DATA_WR = 3'd4,
        ST_DATA_RD = 3'd5
    } spi_state_e;

    localparam logic [7:0] REG_DEVID_AD  = 8'h00;
    localparam logic [7:0] REG_DEVID_MST = 8'h01;
    localparam logic [7:0] REG_PARTID    = 8'h02;

    localparam int STAT_WR_DONE   = 0;
    localparam int STAT_FRAME_ERR = 1;
    localparam int STAT_IRQ_EN    = 7;

    // Identification registers occupy the bottom of the map and never change.
    function automatic logic is_ro_reg(input logic [7:0] idx);
        return (idx <= REG_PARTID);
    endfunction

endpackage

// File: rtl/wb_spi_accel_responder_if.sv
// Wishbone slave bus bundle for the accelerometer responder; the master
// modport is the host side, the slave modport the register bank side.
interface wb_spi_accel_responder_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_we_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
        output wb_dat_o, wb_ack_o
    );

    modport master (
        output wb_adr_i, wb_dat_i, wb_we_i, wb_stb_i, wb_cyc_i, wb_sel_i,
        input  wb_dat_o, wb_ack_o
    );

endinterface

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the system clock domain and flags
// edges of the synchronised sclk and cs_n.
module spi_pin_sync #(
    parameter int SYNC = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sclk,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_cs_n,
    output logic o_mosi,
    output logic o_sclk_rise,
    output logic o_sclk_fall,
    output logic o_cs_rise,
    output logic o_cs_fall
);

    logic [SYNC-1:0] r_sclk_sync;
    logic [SYNC-1:0] r_cs_sync;
    logic [SYNC-1:0] r_mosi_sync;
    logic            r_sclk_prev;
    logic            r_cs_prev;

    // Synchroniser chains plus one history flop for edge detection; cs_n idles deasserted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= {SYNC{1'b0}};
            r_cs_sync   <= {SYNC{1'b1}};
            r_mosi_sync <= {SYNC{1'b0}};
            r_sclk_prev <= 1'b0;
            r_cs_prev   <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC-2:0], i_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC-2:0], i_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC-2:0], i_mosi};
            r_sclk_prev <= r_sclk_sync[SYNC-1];
            r_cs_prev   <= r_cs_sync[SYNC-1];
        end
    end

    assign o_cs_n      = r_cs_sync[SYNC-1];
    assign o_mosi      = r_mosi_sync[SYNC-1];
    assign o_sclk_rise = r_sclk_sync[SYNC-1] & ~r_sclk_prev;
    assign o_sclk_fall = ~r_sclk_sync[SYNC-1] & r_sclk_prev;
    assign o_cs_rise   = r_cs_sync[SYNC-1] & ~r_cs_prev;
    assign o_cs_fall   = ~r_cs_sync[SYNC-1] & r_cs_prev;

endmodule

// File: rtl/wb_spi_accel_responder.sv
// ADXL362-style SPI mode-0 register-bank target with a Wishbone side port
// for preload, inspection and status/interrupt control.
module wb_spi_accel_responder
    import spi_accel_pkg::*;
#(
    parameter int         AW        = 6,
    parameter int         SYNC      = 2,
    parameter logic [7:0] DEVID_AD  = 8'hAD,
    parameter logic [7:0] DEVID_MST = 8'h1D,
    parameter logic [7:0] PARTID    = 8'hF2
) (
    input  logic                             wb_clk_i,
    input  logic                             wb_rst_n_i,
    wb_spi_accel_responder_if.slave          wb,
    input  logic                             i_spi_sclk,
    input  logic                             i_spi_cs_n,
    input  logic                             i_spi_mosi,
    output logic                             o_spi_miso,
    output logic                             o_miso_oe,
    output logic                             o_irq
);

    localparam int NREG = 1 << AW;

    logic w_cs_n, w_mosi, w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;

    spi_pin_sync #(.SYNC(SYNC)) u_sync (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_n_i),
        .i_sclk      (i_spi_sclk),
        .i_cs_n      (i_spi_cs_n),
        .i_mosi      (i_spi_mosi),
        .o_cs_n      (w_cs_n),
        .o_mosi      (w_mosi),
        .o_sclk_rise (w_sclk_rise),
        .o_sclk_fall (w_sclk_fall),
        .o_cs_rise   (w_cs_rise),
        .o_cs_fall   (w_cs_fall)
    );

    spi_state_e      r_state, w_state_nxt;
    logic [2:0]      r_bit_cnt;
    logic [7:0]      r_shift_in, r_shift_out;
    logic [AW-1:0]   r_addr;
    logic            r_is_rd, r_commit_v, r_wr_seen, r_miso;
    logic [7:0]      r_regs [NREG];
    logic            r_ack, r_wr_done, r_frame_err, r_irq_en, r_irq;
    logic [31:0]     r_dat;

    logic [7:0]      w_byte_in;
    logic [AW-1:0]   w_addr_in;
    logic            w_byte_done, w_cmd_ok, w_spi_reg_we;

    assign w_byte_in    = {r_shift_in[6:0], w_mosi};
    assign w_addr_in    = w_byte_in[AW-1:0];
    assign w_cmd_ok     = (w_byte_in == CMD_WR) || (w_byte_in == CMD_RD);
    assign w_byte_done  = w_sclk_rise && !w_cs_rise && !w_cs_fall &&
                          (r_state != ST_IDLE) && (r_bit_cnt == 3'd7);
    assign w_spi_reg_we = r_commit_v && !is_ro_reg(8'(r_addr));

    // Frame state register.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next frame state: chip-select edges override byte-boundary transitions.
    always_comb begin
        w_state_nxt = r_state;
        if (w_cs_rise) begin
            w_state_nxt = ST_IDLE;
        end else if (w_cs_fall) begin
            w_state_nxt = ST_CMD;
        end else if (w_byte_done) begin
            case (r_state)
                ST_CMD:  w_state_nxt = w_cmd_ok ? ST_ADDR : ST_IGNORE;
                ST_ADDR: w_state_nxt = r_is_rd ? ST_DATA_RD : ST_DATA_WR;
                default: w_state_nxt = r_state;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // SPI datapath: shift in on sclk rise, shift out on sclk fall, commit a
    // written byte one cycle after its last bit.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_bit_cnt   <= 3'd0;
            r_shift_in  <= 8'h00;
            r_shift_out <= 8'h00;
            r_addr      <= {AW{1'b0}};
            r_is_rd     <= 1'b0;
            r_commit_v  <= 1'b0;
            r_wr_seen   <= 1'b0;
            r_miso      <= 1'b0;
        end else begin
            r_commit_v <= 1'b0;
            if (w_cs_fall) begin
                r_bit_cnt <= 3'd0;
                r_wr_seen <= 1'b0;
                r_miso    <= 1'b0;
            end else if (w_cs_rise) begin
                r_bit_cnt <= 3'd0;
                r_miso    <= 1'b0;
            end else if (r_state != ST_IDLE) begin
                if (w_sclk_rise) begin
                    r_bit_cnt  <= r_bit_cnt + 3'd1;
                    r_shift_in <= w_byte_in;
                end
                if (w_byte_done) begin
                    case (r_state)
                        ST_CMD: r_is_rd <= (w_byte_in == CMD_RD);
                        ST_ADDR: begin
                            if (r_is_rd) begin
                                r_shift_out <= r_regs[w_addr_in];
                                r_addr      <= w_addr_in + AW'(1);
                            end else begin
                                r_addr      <= w_addr_in;
                            end
                        end
                        ST_DATA_WR: r_commit_v <= 1'b1;
                        ST_DATA_RD: begin
                            r_shift_out <= r_regs[r_addr];
                            r_addr      <= r_addr + AW'(1);
                        end
                        default: r_is_rd <= r_is_rd;
                    endcase
                end
                if (w_sclk_fall) begin
                    if (r_state == ST_DATA_RD) begin
                        r_miso      <= r_shift_out[7];
                        r_shift_out <= {r_shift_out[6:0], 1'b0};
                    end else begin
                        r_miso      <= 1'b0;
                    end
                end
            end
            if (r_commit_v) begin
                r_addr    <= r_addr + AW'(1);
                r_wr_seen <= 1'b1;
            end
        end
    end

    logic          w_req, w_is_stat, w_wb_reg_we, w_stat_we;
    logic [AW-1:0] w_wb_idx;
    logic          w_set_wr, w_set_fe, w_clr_wr, w_clr_fe;
    logic          w_unused;

    assign w_req       = wb.wb_stb_i & wb.wb_cyc_i & ~r_ack;
    assign w_is_stat   = wb.wb_adr_i[8];
    assign w_wb_idx    = wb.wb_adr_i[AW+1:2];
    assign w_wb_reg_we = w_req & wb.wb_we_i & ~w_is_stat & ~is_ro_reg(8'(w_wb_idx));
    assign w_stat_we   = w_req & wb.wb_we_i & w_is_stat;
    assign w_set_wr    = w_cs_rise && (r_state != ST_IDLE) && (r_wr_seen || r_commit_v);
    assign w_set_fe    = (w_cs_rise && (r_state != ST_IDLE) && (r_bit_cnt != 3'd0)) ||
                         (w_byte_done && (r_state == ST_CMD) && !w_cmd_ok);
    assign w_clr_wr    = w_stat_we & wb.wb_dat_i[STAT_WR_DONE];
    assign w_clr_fe    = w_stat_we & wb.wb_dat_i[STAT_FRAME_ERR];
    assign w_unused    = ^{wb.wb_sel_i, wb.wb_adr_i, wb.wb_dat_i[31:8]};

    // Register bank: an SPI commit beats a same-cycle Wishbone write to the same index.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= 8'h00;
            end
            r_regs[REG_DEVID_AD[AW-1:0]]  <= DEVID_AD;
            r_regs[REG_DEVID_MST[AW-1:0]] <= DEVID_MST;
            r_regs[REG_PARTID[AW-1:0]]    <= PARTID;
        end else begin
            if (w_wb_reg_we && !(w_spi_reg_we && (r_addr == w_wb_idx))) begin
                r_regs[w_wb_idx] <= wb.wb_dat_i[7:0];
            end
            if (w_spi_reg_we) begin
                r_regs[r_addr] <= r_shift_in;
            end
        end
    end

    // Wishbone ack/read data and status flags; a set event beats a same-cycle clear.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_ack       <= 1'b0;
            r_dat       <= 32'd0;
            r_wr_done   <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq_en    <= 1'b0;
            r_irq       <= 1'b0;
        end else begin
            r_ack <= w_req;
            if (w_req) begin
                r_dat <= w_is_stat ? {24'd0, r_irq_en, 5'd0, r_frame_err, r_wr_done}
                                   : {24'd0, r_regs[w_wb_idx]};
            end
            r_wr_done   <= w_set_wr | (r_wr_done & ~w_clr_wr);
            r_frame_err <= w_set_fe | (r_frame_err & ~w_clr_fe);
            if (w_stat_we) begin
                r_irq_en <= wb.wb_dat_i[STAT_IRQ_EN];
            end
            r_irq <= r_wr_done & r_irq_en;
        end
    end

    assign wb.wb_ack_o = r_ack;
    assign wb.wb_dat_o = r_dat;
    assign o_spi_miso  = r_miso;
    assign o_miso_oe   = ~w_cs_n;
    assign o_irq       = r_irq;

endmodule

// File: tb/tb_wb_spi_accel_responder.sv
// Directed bench for wb_spi_accel_responder: SPI master and Wishbone host
// driven from tasks, expected values hand-computed in each scenario.
module tb_wb_spi_accel_responder;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic sclk  = 1'b0;
    logic cs_n  = 1'b1;
    logic mosi  = 1'b0;
    logic miso, oe, irq;
    int   tests_run    = 0;
    int   tests_failed = 0;

    localparam logic [31:0] STAT_ADR = 32'h0000_0100;

    wb_spi_accel_responder_if wb_if ();

    wb_spi_accel_responder dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .wb         (wb_if),
        .i_spi_sclk (sclk),
        .i_spi_cs_n (cs_n),
        .i_spi_mosi (mosi),
        .o_spi_miso (miso),
        .o_miso_oe  (oe),
        .o_irq      (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] reg_adr(input int idx);
        return 32'(idx) << 2;
    endfunction

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wb_idle();
        wb_if.wb_stb_i = 1'b0;
        wb_if.wb_cyc_i = 1'b0;
        wb_if.wb_we_i  = 1'b0;
    endtask

    // One Wishbone access; lat = cycles to ack (0 if none), rdat poisoned on timeout.
    task automatic wb_access(input logic we, input logic [31:0] adr, input logic [7:0] d,
                             output logic [31:0] rdat, output int lat);
        wb_if.wb_adr_i = adr;
        wb_if.wb_dat_i = {24'd0, d};
        wb_if.wb_we_i  = we;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_cyc_i = 1'b1;
        lat  = 0;
        rdat = 32'hDEAD_BEEF;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (wb_if.wb_ack_o === 1'b1) begin
                lat  = i;
                rdat = wb_if.wb_dat_o;
                break;
            end
        end
        wb_idle();
        @(negedge clk);
    endtask

    task automatic wb_read(input logic [31:0] adr, output logic [31:0] rdat);
        int lat;
        wb_access(1'b0, adr, 8'h00, rdat, lat);
    endtask

    task automatic wb_write(input logic [31:0] adr, input logic [7:0] d);
        logic [31:0] unused_d;
        int          unused_l;
        wb_access(1'b1, adr, d, unused_d, unused_l);
    endtask

    task automatic spi_bit(input logic b, output logic r);
        mosi = b;
        wait_clks(6);
        r    = miso;
        sclk = 1'b1;
        wait_clks(6);
        sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic spi_begin();
        cs_n = 1'b0;
        wait_clks(8);
    endtask

    task automatic spi_end();
        wait_clks(6);
        cs_n = 1'b1;
        wait_clks(8);
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int          lat;
        logic [7:0]  exp_id [3];
        logic        a1, a2, a3;
        exp_id = '{8'hAD, 8'h1D, 8'hF2};
        rst_n = 1'b0;
        wait_clks(3);
        tests_run++;
        if ({wb_if.wb_ack_o, miso, oe, irq} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_outs: ack/miso/oe/irq=%b expected 0000", {wb_if.wb_ack_o, miso, oe, irq});
        end
        tests_run++;
        if (wb_if.wb_dat_o !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_dat: got %h expected 00000000", wb_if.wb_dat_o);
        end
        rst_n = 1'b1;
        wait_clks(2);
        for (int i = 0; i < 3; i++) begin
            wb_access(1'b0, reg_adr(i), 8'h00, d, lat);
            tests_run++;
            if (d !== {24'd0, exp_id[i]}) begin
                tests_failed++;
                $display("FAIL id_reg%0d: got %h expected %h", i, d, {24'd0, exp_id[i]});
            end
            tests_run++;
            if (lat !== 1) begin
                tests_failed++;
                $display("FAIL ack_latency%0d: got %0d expected 1", i, lat);
            end
            tests_run++;
            if (wb_if.wb_ack_o !== 1'b0) begin
                tests_failed++;
                $display("FAIL ack_width%0d: ack still %b expected 0", i, wb_if.wb_ack_o);
            end
        end
        // Held strobe: ack must pulse, drop for a cycle, then pulse again.
        wb_if.wb_adr_i = reg_adr(0);
        wb_if.wb_we_i  = 1'b0;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_cyc_i = 1'b1;
        @(negedge clk); a1 = wb_if.wb_ack_o;
        @(negedge clk); a2 = wb_if.wb_ack_o;
        @(negedge clk); a3 = wb_if.wb_ack_o;
        wb_idle();
        @(negedge clk);
        tests_run++;
        if ({a1, a2, a3} !== 3'b101) begin
            tests_failed++;
            $display("FAIL ack_no_b2b: got %b expected 101", {a1, a2, a3});
        end
        wb_read(STAT_ADR, d);
        tests_run++;
        if (d !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_status: got %h expected 00000000", d);
        end
    endtask

    task automatic test_spi_write();
        logic [7:0]  rx;
        logic [31:0] d;
        logic [7:0]  bytes [4];
        bytes = '{8'h0A, 8'h20, 8'h55, 8'hAA};
        spi_begin();
        for (int i = 0; i < 4; i++) spi_byte(bytes[i], rx);
        tests_run++;
        if (oe !== 1'b1) begin
            tests_failed++;
            $display("FAIL miso_oe_active: got %b expected 1", oe);
        end
        spi_end();
        wb_read(reg_adr(32'h20), d);
        tests_run++;
        if (d !== 32'h55) begin tests_failed++; $display("FAIL wr_reg20: got %h expected 00000055", d); end
        wb_read(reg_adr(32'h21), d);
        tests_run++;
        if (d !== 32'hAA) begin tests_failed++; $display("FAIL wr_reg21: got %h expected 000000aa", d); end
        wb_read(STAT_ADR, d);
        tests_run++;
        if (d !== 32'h01) begin tests_failed++; $display("FAIL wr_done: status %h expected 00000001", d); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_masked: got %b expected 0", irq); end
        wb_write(STAT_ADR, 8'h80);
        wait_clks(2);
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_enabled: got %b expected 1", irq); end
        wb_read(STAT_ADR, d);
        tests_run++;
        if (d !== 32'h81) begin tests_failed++; $display("FAIL status_irq_en: got %h expected 00000081", d); end
        wb_write(STAT_ADR, 8'h01);
        wait_clks(2);
        wb_read(STAT_ADR, d);
        tests_run++;
        if (d !== 32'h00 || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL w1c_wr_done: status %h irq %b expected 00000000 0", d, irq);
        end
    endtask

    task automatic test_spi_read_wrap();
        logic [7:0]  rx [4];
        logic [7:0]  tx [4];
        logic [31:0] d;
        tx = '{8'h0B, 8'h3F, 8'h00, 8'h00};
        wb_write(reg_adr(32'h3F), 8'h12);
        wb_write(reg_adr(0), 8'h55);
        wb_read(reg_adr(0), d);
        tests_run++;
        if (d !== 32'hAD) begin tests_failed++; $display("FAIL wb_ro_write: got %h expected 000000ad", d); end
        spi_begin();
        for (int i = 0; i < 4; i++) spi_byte(tx[i], rx[i]);
        spi_end();
        tests_run++;
        if ({rx[0], rx[1]} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL miso_quiet_hdr: got %h expected 0000", {rx[0], rx[1]});
        end
        tests_run++;
        if (rx[2] !== 8'h12) begin tests_failed++; $display("FAIL rd_reg3f: got %h expected 12", rx[2]); end
        tests_run++;
        if (rx[3] !== 8'hAD) begin tests_failed++; $display("FAIL rd_wrap00: got %h expected ad", rx[3]); end
        wb_read(STAT_ADR, d);
        tests_run++;
        if (d !== 32'h00) begin tests_failed++; $display("FAIL rd_status: got %h expected 00000000", d); end
    endtask

    task automatic test_readonly_and_badcmd();
        logic [7:0]  rx;
        logic [7:0]  acc;
        logic [31:0] d;
        logic [7:0]  wr_seq [5];
        logic [7:0]  bad_seq [3];
        wr_seq  = '{8'h0A, 8'h01, 8'h77, 8'h66, 8'h99};
        bad_seq = '{8'h55, 8'h20, 8'h99};
        spi_begin();
        for (int i = 0; i < 5; i++) spi_byte(wr_seq[i], rx);
        spi_end();
        wb_read(reg_adr(1), d);
        tests_run++;
        if (d !== 32'h1D) begin tests_failed++; $display("FAIL ro_reg01: got %h expected 0000001d", d); end
        wb_read(reg_adr(2), d);
        tests_run++;
        if (d !== 32'hF2) begin tests_failed++; $display("FAIL ro_reg02: got %h expected 000000f2", d); end
        wb_read(reg_adr(3), d);
        tests_run++;
        if (d !== 32'h99) begin tests_failed++; $display("FAIL ro_addr_inc: reg03 %h expected 00000099", d); end
        wb_write(STAT_ADR, 8'h03);
        acc = 8'h00;
        spi_begin();
        for (int i = 0; i < 3; i++) begin
            spi_byte(bad_seq[i], rx);
            acc = acc | rx;
        end
        spi_end();
        tests_run++;
        if (acc !== 8'h00) begin tests_failed++; $display("FAIL badcmd_miso: OR of rx %h expected 00", acc); end
        wb_read(STAT_ADR, d);
        tests_run++;
        if (d !== 32'h02) begin tests_failed++; $display("FAIL badcmd_frame_err: status %h expected 00000002", d); end
        wb_read(reg_adr(32'h20), d);
        tests_run++;
        if (d !== 32'h55) begin tests_failed++; $display("FAIL badcmd_no_write: reg20 %h expected 00000055", d); end
        wb_write(STAT_ADR, 8'h02);
    endtask

    task automatic test_abort();
        logic [7:0]  rx;
        logic        r;
        logic [7:0]  part;
        logic [31:0] d;
        part = 8'hC3;
        spi_begin();
        spi_byte(8'h0A, rx);
        spi_byte(8'h30, rx);
        for (int i = 7; i >= 3; i--) spi_bit(part[i], r);
        spi_end();
        wb_read(reg_adr(32'h30), d);
        tests_run++;
        if (d !== 32'h00) begin tests_failed++; $display("FAIL abort_no_write: reg30 %h expected 00000000", d); end
        wb_read(STAT_ADR, d);
        tests_run++;
        if (d !== 32'h02) begin tests_failed++; $display("FAIL abort_frame_err: status %h expected 00000002", d); end
        wb_write(STAT_ADR, 8'h02);
        wb_read(STAT_ADR, d);
        tests_run++;
        if (d !== 32'h00) begin tests_failed++; $display("FAIL w1c_frame_err: status %h expected 00000000", d); end
    endtask

    task automatic test_collision();
        logic [7:0]  rx;
        logic        r;
        logic [7:0]  val;
        logic [31:0] d;
        val = 8'h33;
        spi_begin();
        spi_byte(8'h0A, rx);
        spi_byte(8'h10, rx);
        for (int i = 7; i >= 1; i--) spi_bit(val[i], r);
        mosi = val[0];
        wait_clks(6);
        sclk = 1'b1;
        // Two sync stages + one cycle to act on the edge: commit lands on the 4th rising clock.
        wait_clks(3);
        wb_if.wb_adr_i = reg_adr(32'h10);
        wb_if.wb_dat_i = 32'h44;
        wb_if.wb_we_i  = 1'b1;
        wb_if.wb_stb_i = 1'b1;
        wb_if.wb_cyc_i = 1'b1;
        @(negedge clk);
        tests_run++;
        if (wb_if.wb_ack_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL collision_ack: got %b expected 1", wb_if.wb_ack_o);
        end
        wb_idle();
        wait_clks(2);
        sclk = 1'b0;
        spi_end();
        wb_read(reg_adr(32'h10), d);
        tests_run++;
        if (d !== 32'h33) begin tests_failed++; $display("FAIL collision_spi_wins: reg10 %h expected 00000033", d); end
    endtask

    task automatic test_async_reset();
        logic [7:0]  rx;
        logic        r;
        logic [31:0] d;
        wb_write(STAT_ADR, 8'h80);
        wait_clks(2);
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_irq: got %b expected 1", irq); end
        spi_begin();
        spi_byte(8'h0A, rx);
        spi_byte(8'h21, rx);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, r);
        #3;
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk  = 1'b0;
        #1;
        tests_run++;
        if ({oe, irq, miso, wb_if.wb_ack_o} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL async_reset_outs: oe/irq/miso/ack=%b expected 0000", {oe, irq, miso, wb_if.wb_ack_o});
        end
        wait_clks(3);
        rst_n = 1'b1;
        wait_clks(2);
        wb_read(reg_adr(32'h20), d);
        tests_run++;
        if (d !== 32'h00) begin tests_failed++; $display("FAIL async_reset_reg20: got %h expected 00000000", d); end
        wb_read(reg_adr(32'h10), d);
        tests_run++;
        if (d !== 32'h00) begin tests_failed++; $display("FAIL async_reset_reg10: got %h expected 00000000", d); end
        wb_read(reg_adr(1), d);
        tests_run++;
        if (d !== 32'h1D) begin tests_failed++; $display("FAIL async_reset_reg01: got %h expected 0000001d", d); end
        wb_read(STAT_ADR, d);
        tests_run++;
        if (d !== 32'h00) begin tests_failed++; $display("FAIL async_reset_status: got %h expected 00000000", d); end
    endtask

    initial begin
        wb_if.wb_adr_i = 32'd0;
        wb_if.wb_dat_i = 32'd0;
        wb_if.wb_sel_i = 4'hF;
        wb_idle();
        @(negedge clk);
        test_reset();
        test_spi_write();
        test_spi_read_wrap();
        test_readonly_and_badcmd();
        test_abort();
        test_collision();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
